// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: maps byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests
// onto a word-addressed DataMemory, with read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int DEPTH      = 1024,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic        fault_sticky,
  output logic        dm_memRead,
  output logic        dm_memWrite,
  output logic [31:0] dm_address,
  output logic [31:0] dm_writeData,
  input  logic [31:0] dm_readData
);

  // state  | meaning
  // IDLE   | decode the incoming request; loads and word stores finish here
  // RMW_WR | write back the merged word captured during the previous cycle
  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] merged_q, merged_d;
  logic [29:0] widx_q, widx_d;
  logic        sticky_q;

  logic [1:0]  blane;
  logic        hlane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ext;
  logic [31:0] merged;
  logic        is_access;
  logic        bad;

  // Endianness only changes which physical lane an address offset selects.
  assign blane = BIG_ENDIAN ? ~addr[1:0] : addr[1:0];
  assign hlane = BIG_ENDIAN ? ~addr[1]   : addr[1];

  always_comb begin
    rd_byte = 8'h00;
    merged  = dm_readData;
    case (blane)
      2'd0: rd_byte = dm_readData[7:0];
      2'd1: rd_byte = dm_readData[15:8];
      2'd2: rd_byte = dm_readData[23:16];
      default: rd_byte = dm_readData[31:24];
    endcase
    rd_half = hlane ? dm_readData[31:16] : dm_readData[15:0];
    if (size == 2'd0) begin
      case (blane)
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        default: merged[31:24] = wdata[7:0];
      endcase
    end else if (hlane) begin
      merged[31:16] = wdata[15:0];
    end else begin
      merged[15:0] = wdata[15:0];
    end
    case (size)
      2'd0:    ext = {{24{~unsigned_ld & rd_byte[7]}}, rd_byte};
      2'd1:    ext = {{16{~unsigned_ld & rd_half[15]}}, rd_half};
      default: ext = dm_readData;
    endcase
  end

  assign is_access = mem_read | mem_write;
  assign bad = (size == 2'd3) || (mem_read && mem_write) ||
               (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00) ||
               (is_access && ({2'b00, addr[31:2]} >= 32'(DEPTH)));

  always_comb begin
    state_d      = state_q;
    merged_d     = merged_q;
    widx_d       = widx_q;
    stall        = 1'b0;
    fault        = 1'b0;
    dm_memRead   = 1'b0;
    dm_memWrite  = 1'b0;
    dm_address   = 32'h0;
    dm_writeData = 32'h0;
    load_data    = 32'h0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          dm_address = {2'b00, addr[31:2]};
          if (req_valid) begin
            if (bad) begin
              fault = 1'b1;
            end else if (mem_read) begin
              dm_memRead = 1'b1;
              load_data  = ext;
            end else if (mem_write) begin
              if (size == 2'd2) begin
                dm_memWrite  = 1'b1;
                dm_writeData = wdata;
              end else begin
                dm_memRead = 1'b1;
                stall      = 1'b1;
                merged_d   = merged;
                widx_d     = addr[31:2];
                state_d    = RMW_WR;
              end
            end
          end
        end
        RMW_WR: begin
          dm_memWrite  = 1'b1;
          dm_address   = {2'b00, widx_q};
          dm_writeData = merged_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      merged_q <= 32'h0;
      widx_q   <= 30'h0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      merged_q <= merged_d;
      widx_q   <= widx_d;
      sticky_q <= sticky_q | fault;
    end
  end

  assign fault_sticky = sticky_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-addressed DataMemory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, mem_read, mem_write, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] load_data;
  logic        stall, fault, fault_sticky;
  logic        dm_memRead, dm_memWrite;
  logic [31:0] dm_address, dm_writeData, dm_readData;

  logic [31:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(1024), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld), .addr(addr),
    .wdata(wdata), .load_data(load_data), .stall(stall), .fault(fault),
    .fault_sticky(fault_sticky), .dm_memRead(dm_memRead), .dm_memWrite(dm_memWrite),
    .dm_address(dm_address), .dm_writeData(dm_writeData), .dm_readData(dm_readData)
  );

  always @(posedge clk) if (dm_memWrite) mem[dm_address[9:0]] <= dm_writeData;
  assign dm_readData = mem[dm_address[9:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request, then move to the falling edge where outputs are checked.
  task automatic req(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid = v; mem_read = rd; mem_write = wr; size = sz;
    unsigned_ld = uns; addr = a; wdata = wd;
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] wd);
    req(1, 0, 1, 2'd2, 0, a, wd);
    chk("sw_wr", {31'b0, dm_memWrite}, 32'd1);
    step();
  endtask

  initial begin
    rst = 1'b0;
    req(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_rd", {31'b0, dm_memRead}, 0);
    chk("rst_wr", {31'b0, dm_memWrite}, 0);
    chk("rst_addr", dm_address, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_sticky", {31'b0, fault_sticky}, 0);
    step();
    rst = 1'b1;
    req(0, 0, 0, 2'd0, 0, 32'h0, 32'h0);
    chk("idle_ld", load_data, 0);
    chk("idle_strobe", {30'b0, dm_memRead, dm_memWrite}, 0);
    step();

    // word store then load
    req(1, 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    chk("sw_wr", {31'b0, dm_memWrite}, 1);
    chk("sw_rd", {31'b0, dm_memRead}, 0);
    chk("sw_addr", dm_address, 32'd4);
    chk("sw_data", dm_writeData, 32'hDEADBEEF);
    chk("sw_stall", {31'b0, stall}, 0);
    step();
    req(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_rd", {31'b0, dm_memRead}, 1);
    step();

    // byte store read-modify-write
    do_sw(32'h10, 32'h11223344);
    req(1, 0, 1, 2'd0, 0, 32'h11, 32'h000000A5);
    chk("sb_stall", {31'b0, stall}, 1);
    chk("sb_rd", {31'b0, dm_memRead}, 1);
    chk("sb_wr0", {31'b0, dm_memWrite}, 0);
    step();
    chk("sb_rmw_addr", dm_address, 32'd4);
    @(negedge clk);
    chk("sb_wr1", {31'b0, dm_memWrite}, 1);
    chk("sb_rd1", {31'b0, dm_memRead}, 0);
    chk("sb_merged", dm_writeData, 32'h1122A544);
    chk("sb_stall1", {31'b0, stall}, 0);
    chk("sb_fault1", {31'b0, fault}, 0);
    step();
    req(1, 1, 0, 2'd2, 0, 32'h10, 32'h0);
    chk("sb_readback", load_data, 32'h1122A544);
    step();

    // load extraction and extension
    do_sw(32'h10, 32'h80FF7F01);
    req(1, 1, 0, 2'd0, 0, 32'h13, 0); chk("lb_13", load_data, 32'hFFFFFF80); step();
    req(1, 1, 0, 2'd0, 1, 32'h13, 0); chk("lbu_13", load_data, 32'h00000080); step();
    req(1, 1, 0, 2'd1, 0, 32'h12, 0); chk("lh_12", load_data, 32'hFFFF80FF); step();
    req(1, 1, 0, 2'd1, 1, 32'h10, 0); chk("lhu_10", load_data, 32'h00007F01); step();
    req(1, 1, 0, 2'd0, 0, 32'h11, 0); chk("lb_11", load_data, 32'h0000007F); step();
    req(1, 1, 0, 2'd0, 0, 32'h12, 0); chk("lb_12", load_data, 32'hFFFFFFFF); step();
    req(1, 1, 0, 2'd1, 0, 32'h10, 0); chk("lh_10", load_data, 32'h00007F01); step();

    // faults
    chk("sticky_pre", {31'b0, fault_sticky}, 0);
    req(1, 1, 0, 2'd1, 0, 32'h11, 0);
    chk("lh_mis_fault", {31'b0, fault}, 1);
    chk("lh_mis_strobe", {30'b0, dm_memRead, dm_memWrite}, 0);
    chk("lh_mis_stall", {31'b0, stall}, 0);
    chk("lh_mis_ld", load_data, 0);
    step();
    req(0, 0, 0, 2'd0, 0, 0, 0);
    chk("sticky_set", {31'b0, fault_sticky}, 1);
    chk("fault_clear", {31'b0, fault}, 0);
    step();
    req(1, 0, 1, 2'd2, 0, 32'h1002, 32'h12345678);
    chk("sw_oor_fault", {31'b0, fault}, 1);
    chk("sw_oor_strobe", {30'b0, dm_memRead, dm_memWrite}, 0);
    step();
    req(1, 1, 0, 2'd2, 0, 32'h1000, 0);
    chk("lw_1024_fault", {31'b0, fault}, 1);
    step();
    req(1, 1, 0, 2'd2, 0, 32'hFFC, 0);
    chk("lw_1023_ok", {31'b0, fault}, 0);
    chk("lw_1023_rd", {31'b0, dm_memRead}, 1);
    step();
    req(1, 1, 0, 2'd3, 0, 32'h10, 0); chk("size3_fault", {31'b0, fault}, 1); step();
    req(1, 1, 1, 2'd2, 0, 32'h10, 0); chk("rdwr_fault", {31'b0, fault}, 1); step();
    req(1, 1, 0, 2'd2, 0, 32'h12, 0); chk("lw_mis_fault", {31'b0, fault}, 1); step();
    chk("sticky_hold", {31'b0, fault_sticky}, 1);

    // reset during RMW_WR drops the pending write
    do_sw(32'h20, 32'h55667788);
    req(1, 0, 1, 2'd1, 0, 32'h20, 32'h0000BEEF);
    chk("sh_rst_stall", {31'b0, stall}, 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rmw_wr", {31'b0, dm_memWrite}, 0);
    chk("rst_rmw_sticky", {31'b0, fault_sticky}, 0);
    step();
    rst = 1'b1;
    req(1, 1, 0, 2'd2, 0, 32'h20, 0);
    chk("rst_rmw_idle", {31'b0, stall}, 0);
    chk("rst_rmw_mem", load_data, 32'h55667788);
    step();

    // half store followed immediately by a load
    req(1, 0, 1, 2'd1, 0, 32'h10, 32'h1234BEEF);
    chk("sh_stall0", {31'b0, stall}, 1);
    step();
    @(negedge clk);
    chk("sh_stall1", {31'b0, stall}, 0);
    chk("sh_merged", dm_writeData, 32'h80FFBEEF);
    step();
    req(1, 1, 0, 2'd2, 0, 32'h10, 0);
    chk("sh_stall2", {31'b0, stall}, 0);
    chk("sh_lw_low", {16'h0, load_data[15:0]}, 32'h0000BEEF);
    chk("sh_lw_full", load_data, 32'h80FFBEEF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
